// File: rtl/decim_pack_ctrl.sv
// Decimating sample packer: collects DECIM samples into a packing register and
// hands the packed word to an output register when downstream asks for it.
module decim_pack_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DECIM  = 2,
  parameter int DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_en,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_load,
  output logic [WIDTH*DECIM-1:0]     o_dout,
  output logic                       o_dout_valid,
  output logic                       o_full,
  output logic [$clog2(DECIM+1)-1:0] o_count,
  output logic [DROP_W-1:0]          o_drop_cnt
);

  localparam int CW = $clog2(DECIM+1);
  localparam int PW = WIDTH*DECIM;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_FULL} state_t;

  state_t            w_state;
  logic [CW-1:0]     r_count,      w_count_nxt;
  logic [PW-1:0]     r_pack,       w_pack_nxt;
  logic [PW-1:0]     r_dout,       w_dout_nxt;
  logic              r_dout_valid, w_dout_valid_nxt;
  logic [DROP_W-1:0] r_drop,       w_drop_nxt;

  // The sample count is the state register; the named state is decoded from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= '0;
      r_pack       <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_drop       <= '0;
    end else begin
      r_count      <= w_count_nxt;
      r_pack       <= w_pack_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_drop       <= w_drop_nxt;
    end
  end

  always_comb begin
    w_count_nxt      = r_count;
    w_pack_nxt       = r_pack;
    w_dout_nxt       = r_dout;
    w_dout_valid_nxt = 1'b0;
    w_drop_nxt       = r_drop;
    case (w_state)
      S_IDLE, S_FILL: begin
        if (i_en) begin
          w_pack_nxt[int'(r_count)*WIDTH +: WIDTH] = i_din;
          w_count_nxt = r_count + CW'(1);
        end else if (w_state == S_IDLE) begin
          w_pack_nxt = '0;
        end
      end
      S_FULL: begin
        if (i_load) begin
          w_dout_nxt       = r_pack;
          w_dout_valid_nxt = 1'b1;
          // A sample arriving with the transfer starts the next word, so no drop.
          w_pack_nxt = '0;
          if (i_en) begin
            w_pack_nxt[WIDTH-1:0] = i_din;
            w_count_nxt = CW'(1);
          end else begin
            w_count_nxt = '0;
          end
        end else if (i_en && (r_drop != {DROP_W{1'b1}})) begin
          w_drop_nxt = r_drop + DROP_W'(1);
        end
      end
      default: begin
        w_count_nxt = '0;
        w_pack_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    if (r_count == '0)
      w_state = S_IDLE;
    else if (r_count == CW'(DECIM))
      w_state = S_FULL;
    else
      w_state = S_FILL;
    o_full       = (w_state == S_FULL);
    o_count      = r_count;
    o_dout       = r_dout;
    o_dout_valid = r_dout_valid;
    o_drop_cnt   = r_drop;
  end

endmodule
